// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for the 5-stage RV32 pipeline: load-use, multi-cycle MUL, D-cache freeze, branch flush.
// Optional stall-cycle performance counter enabled by defining HAZARD_PERF_CNT_EN.
module hazard_stall_unit #(
   parameter int MUL_LATENCY = 3,
   parameter int CNT_W       = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  ID_rs1,
   input  logic [4:0]  ID_rs2,
   input  logic        ID_use_rs1,
   input  logic        ID_use_rs2,
   input  logic        ID_EX_MemRead,
   input  logic [4:0]  ID_EX_RegisterRd,
   input  logic        ID_EX_is_mul,
   input  logic        dcache_stall,
   input  logic        branch_flush,
   output logic        PC_stall,
   output logic        IF_ID_stall,
   output logic        IF_ID_flush,
   output logic        ID_EX_stall,
   output logic        ID_EX_bubble,
   output logic        EX_MEM_stall,
   output logic        EX_MEM_bubble,
   output logic        mul_done,
   output logic [31:0] stall_cycles
);

   typedef enum logic [0:0] {IDLE, MUL_BUSY} state_t;

   // The start cycle is the first of MUL_LATENCY, and the count reaches 0 on the result cycle.
   localparam logic [CNT_W-1:0] CNT_START = CNT_W'((MUL_LATENCY >= 2) ? (MUL_LATENCY - 2) : 0);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;

   function automatic logic load_use_hit(
      input logic       mem_read,
      input logic [4:0] rd,
      input logic [4:0] rs1,
      input logic [4:0] rs2,
      input logic       use_rs1,
      input logic       use_rs2
   );
      return mem_read && (rd != 5'd0) &&
             ((use_rs1 && (rs1 == rd)) || (use_rs2 && (rs2 == rd)));
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      PC_stall      = 1'b0;
      IF_ID_stall   = 1'b0;
      IF_ID_flush   = 1'b0;
      ID_EX_stall   = 1'b0;
      ID_EX_bubble  = 1'b0;
      EX_MEM_stall  = 1'b0;
      EX_MEM_bubble = 1'b0;
      mul_done      = 1'b0;
      if (!rst_n) begin
         state_nxt = IDLE;
      end else if (dcache_stall) begin
         PC_stall     = 1'b1;
         IF_ID_stall  = 1'b1;
         ID_EX_stall  = 1'b1;
         EX_MEM_stall = 1'b1;
      end else if (state == MUL_BUSY) begin
         if (cnt != '0) begin
            PC_stall      = 1'b1;
            IF_ID_stall   = 1'b1;
            ID_EX_stall   = 1'b1;
            EX_MEM_bubble = 1'b1;
            cnt_nxt       = cnt - 1'b1;
         end else begin
            mul_done  = 1'b1;
            state_nxt = IDLE;
         end
      end else if (ID_EX_is_mul && (MUL_LATENCY >= 2)) begin
         PC_stall      = 1'b1;
         IF_ID_stall   = 1'b1;
         ID_EX_stall   = 1'b1;
         EX_MEM_bubble = 1'b1;
         cnt_nxt       = CNT_START;
         state_nxt     = MUL_BUSY;
      end else begin
         // Single-cycle multiplier: result is ready in the same cycle it enters EX.
         mul_done = ID_EX_is_mul;
         if (branch_flush) begin
            IF_ID_flush  = 1'b1;
            ID_EX_bubble = 1'b1;
         end else if (load_use_hit(ID_EX_MemRead, ID_EX_RegisterRd, ID_rs1, ID_rs2,
                                   ID_use_rs1, ID_use_rs2)) begin
            PC_stall     = 1'b1;
            IF_ID_stall  = 1'b1;
            ID_EX_bubble = 1'b1;
         end
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] perf_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n)        perf_cnt <= '0;
      else if (PC_stall) perf_cnt <= perf_cnt + 32'd1;
   end

   assign stall_cycles = rst_n ? perf_cnt : 32'd0;
`else
   assign stall_cycles = 32'd0;
`endif

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Pipeline stall/flush controller for the 5-stage RV32 core. It is the complement of operand forwarding: it detects the hazards that forwarding cannot resolve and freezes or bubbles the pipeline registers.
- Hazards handled: load-use, the multi-cycle multiplier occupying EX, D-cache miss freeze, and EX-resolved branch flush.
- Sits beside the ID/EX pipeline registers and drives the enables and flushes of the PC, IF/ID, ID/EX and EX/MEM registers.

Parameters:
- MUL_LATENCY, 3, total cycles a MUL-class instruction occupies EX. Legal range 1..15.
- CNT_W, 4, width of the multiplier countdown counter. Must hold MUL_LATENCY-1.

Ports:
- clk  in  1  clock, all state changes on rising edge
- rst_n  in  1  reset, synchronous, active-low
- ID_rs1  in  5  rs1 of instruction in ID
- ID_rs2  in  5  rs2 of instruction in ID
- ID_use_rs1  in  1  ID instruction reads rs1
- ID_use_rs2  in  1  ID instruction reads rs2
- ID_EX_MemRead  in  1  instruction in EX is a load
- ID_EX_RegisterRd  in  5  rd of instruction in EX
- ID_EX_is_mul  in  1  instruction in EX is MUL-class
- dcache_stall  in  1  memory stage not ready
- branch_flush  in  1  EX resolved a misprediction this cycle
- PC_stall  out  1  hold PC
- IF_ID_stall  out  1  hold IF/ID
- IF_ID_flush  out  1  clear IF/ID to NOP
- ID_EX_stall  out  1  hold ID/EX
- ID_EX_bubble  out  1  load NOP into ID/EX
- EX_MEM_stall  out  1  hold EX/MEM and MEM/WB
- EX_MEM_bubble  out  1  load NOP into EX/MEM
- mul_done  out  1  multiplier result valid in EX this cycle
- stall_cycles  out  32  performance counter (see Optional Feature)

Behaviour:
- Reset:
  - rst_n=0 sampled on clk puts the FSM in IDLE, clears cnt to 0, and clears stall_cycles to 0.
  - While rst_n=0, all outputs are driven 0.
- FSM states: IDLE, MUL_BUSY. Outputs are combinational from state, cnt and inputs. State and cnt are registered.
- Priority per cycle, highest first:
  1. dcache_stall
  2. MUL_BUSY / mul start
  3. branch_flush
  4. load-use
- dcache_stall=1 (any state):
  - PC_stall=IF_ID_stall=ID_EX_stall=EX_MEM_stall=1.
  - No bubbles or flushes.
  - State and cnt hold.
  - mul_done=0.
- IDLE with ID_EX_is_mul=1 and MUL_LATENCY>=2:
  - PC_stall=IF_ID_stall=ID_EX_stall=1 and EX_MEM_bubble=1.
  - cnt<=MUL_LATENCY-2; next state MUL_BUSY.
- MUL_LATENCY=1: multiplier never stalls; mul_done=ID_EX_is_mul; MUL_BUSY is unreachable.
- MUL_BUSY:
  - cnt!=0: same stall outputs as the mul start; cnt<=cnt-1.
  - cnt==0: no stall; mul_done=1; next state IDLE.
  - ID_EX_is_mul is ignored in MUL_BUSY.
  - branch_flush and load-use are ignored in MUL_BUSY (a MUL in EX cannot be a branch or a load).
- IDLE, branch_flush=1: IF_ID_flush=1, ID_EX_bubble=1, PC not stalled. This overrides load-use because the ID instruction is discarded.
- IDLE, load-use:
  - Condition: ID_EX_MemRead && ID_EX_RegisterRd!=0 && ((ID_use_rs1 && ID_rs1==Rd) || (ID_use_rs2 && ID_rs2==Rd)).
  - Response: PC_stall=IF_ID_stall=1 and ID_EX_bubble=1 for exactly one cycle.
  - The condition self-clears once the bubble enters EX.
- Register x0 never causes a hazard.
- Mutual exclusion: ID_EX_stall and ID_EX_bubble are never both 1; IF_ID_stall and IF_ID_flush are never both 1.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined: stall_cycles increments by 1 on every clk edge where PC_stall=1 and rst_n=1. It wraps modulo 2^32 (0xFFFFFFFF -> 0) and resets to 0.
- Undefined: stall_cycles is tied to 0 and no counter logic is synthesized.

Test Plan:
- Load-use: ID_EX_MemRead=1, Rd=5, ID_rs1=5, ID_use_rs1=1 -> one cycle of PC_stall=IF_ID_stall=ID_EX_bubble=1. Next cycle, with MemRead=0, all 0.
- x0 guard: same stimulus with Rd=0 and ID_rs1=0 -> no stall. Same stimulus with ID_rs2=5 and ID_use_rs2=0 -> no stall.
- MUL, MUL_LATENCY=3: ID_EX_is_mul=1 -> stalls in cycles 1 and 2, mul_done=1 in cycle 3, IDLE in cycle 4. EX_MEM_bubble=1 in cycles 1 and 2.
- dcache freeze during MUL: assert dcache_stall for 4 cycles at cycle 2 -> cnt held at 1, all four stall outputs=1. mul_done arrives exactly 5 cycles after the freeze began.
- Branch vs load-use: branch_flush=1 together with a load-use condition -> IF_ID_flush=1, ID_EX_bubble=1, PC_stall=0, IF_ID_stall=0.
- Reset mid-MUL plus counter: rst_n=0 at cycle 2 of MUL_BUSY -> state IDLE, outputs 0, stall_cycles=0. With HAZARD_PERF_CNT_EN, a prior load-use plus a 3-cycle MUL yields stall_cycles=3.
